// File: rtl/drone_cam_ui_pkg.sv
// Shared constants for the Drone_Cam front-panel UI: default timing values and
// the channel assignment of the selector buttons.
package drone_cam_ui_pkg;

    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DEB_CNT_DEFAULT     = 1048575;
    localparam int LONG_CNT_DEFAULT    = 50000000;

    localparam int CH_FRAME = 0;
    localparam int CH_HDMI  = 2;
    localparam int CH_STAT  = 3;

endpackage

// File: rtl/btn_debounce_ch.sv
// Single button channel: synchroniser, debouncer with private timer, registered
// press/release pulses and, with BTN_CTRL_LONG_PRESS_EN, a long-press hold timer.
module btn_debounce_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 16,
    parameter int DEB_W       = 5,
    parameter int LONG_CNT    = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_in,
    output logic btn_lvl,
    output logic btn_press,
    output logic btn_rel,
    output logic long_press
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_W-1:0]       tmr_q;
    logic [DEB_W-1:0]       tmr_d;
    logic                   stb_q;
    logic                   stb_d;
    logic                   stb_dly_q;
    logic                   press_q;
    logic                   rel_q;
    logic                   s_s;

    // Unsupported configurations elaborate an empty marker block.
    if (SYNC_STAGES < 2 || DEB_CNT < 2 || (DEB_CNT >> DEB_W) != 0 || LONG_CNT < 2) begin : g_param_out_of_range
    end

    assign s_s = sync_q[SYNC_STAGES-1];

    // Debounce next state: a level must differ from stb for DEB_CNT cycles in a row.
    always_comb begin
        stb_d = stb_q;
        tmr_d = '0;
        if (s_s != stb_q) begin
            if (tmr_q == DEB_W'(DEB_CNT - 1)) begin
                stb_d = s_s;
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + DEB_W'(1);
            end
        end else begin
            tmr_d = '0;
        end
    end

    // Synchroniser, debounce state and edge pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q    <= '0;
            tmr_q     <= '0;
            stb_q     <= 1'b0;
            stb_dly_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in};
            tmr_q     <= tmr_d;
            stb_q     <= stb_d;
            stb_dly_q <= stb_q;
            press_q   <= stb_q & ~stb_dly_q;
            rel_q     <= ~stb_q & stb_dly_q;
        end
    end

    assign btn_lvl   = stb_q;
    assign btn_press = press_q;
    assign btn_rel   = rel_q;

`ifdef BTN_CTRL_LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CNT + 1);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              fired_q;
    logic              long_q;
    logic              hold_top_s;

    assign hold_top_s = (hold_q == HOLD_W'(LONG_CNT - 1));

    // Hold timer saturates at LONG_CNT-1 so a single hold yields one pulse.
    always_comb begin
        hold_d = hold_q;
        if (!stb_q) begin
            hold_d = '0;
        end else if (!hold_top_s) begin
            hold_d = hold_q + HOLD_W'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Hold timer and one-shot long-press pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= stb_q & hold_top_s;
            long_q  <= stb_q & hold_top_s & ~fired_q;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/btn_ctrl_select.sv
// Front-panel button block: NUM_BTN independent debounced channels feeding
// per-channel selector counters. Long-press clear enabled by BTN_CTRL_LONG_PRESS_EN.
module btn_ctrl_select
    import drone_cam_ui_pkg::*;
#(
    parameter int NUM_BTN     = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DEB_CNT     = DEB_CNT_DEFAULT,
    parameter int DEB_W       = 20,
    parameter int CNT_W       = 2,
    parameter int CNT_MAX     = 3,
    parameter int LONG_CNT    = LONG_CNT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_BTN-1:0]       btn_in,
    input  logic [NUM_BTN-1:0]       cnt_sat,
    input  logic [NUM_BTN-1:0]       cnt_clr,
    output logic [NUM_BTN-1:0]       btn_lvl,
    output logic [NUM_BTN-1:0]       btn_press,
    output logic [NUM_BTN-1:0]       btn_rel,
    output logic [NUM_BTN*CNT_W-1:0] cnt_out,
    output logic [NUM_BTN-1:0]       long_press
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             clr_s;

        btn_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CNT     (DEB_CNT),
            .DEB_W       (DEB_W),
            .LONG_CNT    (LONG_CNT)
        ) u_deb (
            .clk        (clk),
            .rstn       (rstn),
            .btn_in     (btn_in[i]),
            .btn_lvl    (btn_lvl[i]),
            .btn_press  (btn_press[i]),
            .btn_rel    (btn_rel[i]),
            .long_press (long_press[i])
        );

        // A long press acts as a clear, so both share the top priority.
        assign clr_s = cnt_clr[i] | long_press[i];

        // Selector next value: clear beats press; wrap or saturate at CNT_MAX.
        always_comb begin
            cnt_d = cnt_q;
            if (clr_s) begin
                cnt_d = '0;
            end else if (btn_press[i]) begin
                if (cnt_q >= CNT_W'(CNT_MAX)) begin
                    cnt_d = cnt_sat[i] ? CNT_W'(CNT_MAX) : '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = cnt_q;
            end
        end

        // Selector counter register.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_out[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_btn_ctrl_select.sv
// Directed bench for btn_ctrl_select with short debounce/long-press timings.
// Long-press checks are compiled in when BTN_CTRL_LONG_PRESS_EN is defined.
module tb_btn_ctrl_select;

    localparam int NUM_BTN = 4;
    localparam int CNT_W   = 2;

    logic                     clk;
    logic                     rstn;
    logic [NUM_BTN-1:0]       btn_in;
    logic [NUM_BTN-1:0]       cnt_sat;
    logic [NUM_BTN-1:0]       cnt_clr;
    logic [NUM_BTN-1:0]       btn_lvl;
    logic [NUM_BTN-1:0]       btn_press;
    logic [NUM_BTN-1:0]       btn_rel;
    logic [NUM_BTN*CNT_W-1:0] cnt_out;
    logic [NUM_BTN-1:0]       long_press;

    int n_checks = 0;
    int n_fail   = 0;

    btn_ctrl_select #(
        .NUM_BTN     (NUM_BTN),
        .SYNC_STAGES (2),
        .DEB_CNT     (16),
        .DEB_W       (5),
        .CNT_W       (CNT_W),
        .CNT_MAX     (3),
        .LONG_CNT    (64)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_in     (btn_in),
        .cnt_sat    (cnt_sat),
        .cnt_clr    (cnt_clr),
        .btn_lvl    (btn_lvl),
        .btn_press  (btn_press),
        .btn_rel    (btn_rel),
        .cnt_out    (cnt_out),
        .long_press (long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_ch(input int ch);
        btn_in[ch] = 1'b1;
        repeat (20) tick();
        btn_in[ch] = 1'b0;
        repeat (20) tick();
    endtask

    logic [NUM_BTN-1:0] seen_lvl, seen_press, seen_rel, seen_long;
    logic [1:0] exp_wrap [5];
    logic [1:0] exp_sat  [5];

    initial begin
        exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_sat  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rstn    = 1'b0;
        btn_in  = '0;
        cnt_sat = '0;
        cnt_clr = '0;
        repeat (3) tick();
        check("reset_outputs", {btn_lvl, btn_press, btn_rel, cnt_out, long_press}, 32'd0);
        rstn = 1'b1;
        repeat (2) tick();

        // Clean press on ch0
        btn_in[0] = 1'b1;
        repeat (17) tick();
        check("clean_lvl_t17", 32'(btn_lvl[0]), 32'd0);
        tick();
        check("clean_lvl_t18", 32'(btn_lvl[0]), 32'd1);
        check("clean_press_t18", 32'(btn_press[0]), 32'd0);
        tick();
        check("clean_press_t19", 32'(btn_press[0]), 32'd1);
        check("clean_cnt_t19", 32'(cnt_out[1:0]), 32'd0);
        tick();
        check("clean_press_t20", 32'(btn_press[0]), 32'd0);
        check("clean_cnt_t20", 32'(cnt_out[1:0]), 32'd1);
        repeat (20) tick();
        btn_in[0] = 1'b0;
        repeat (18) tick();
        check("clean_lvl_rel_t18", 32'(btn_lvl[0]), 32'd0);
        check("clean_rel_t18", 32'(btn_rel[0]), 32'd0);
        tick();
        check("clean_rel_t19", 32'(btn_rel[0]), 32'd1);
        tick();
        check("clean_rel_t20", 32'(btn_rel[0]), 32'd0);
        check("clean_cnt_after_rel", 32'(cnt_out[1:0]), 32'd1);

        // Bounce rejection on ch1
        seen_lvl = '0; seen_press = '0; seen_rel = '0;
        for (int k = 0; k < 20; k++) begin
            btn_in[1] = ~btn_in[1];
            for (int j = 0; j < 5; j++) begin
                tick();
                seen_lvl |= btn_lvl; seen_press |= btn_press; seen_rel |= btn_rel;
            end
        end
        btn_in[1] = 1'b0;
        for (int j = 0; j < 25; j++) begin
            tick();
            seen_lvl |= btn_lvl; seen_press |= btn_press; seen_rel |= btn_rel;
        end
        check("bounce_lvl", 32'(seen_lvl[1]), 32'd0);
        check("bounce_press", 32'(seen_press[1]), 32'd0);
        check("bounce_rel", 32'(seen_rel[1]), 32'd0);
        check("bounce_cnt", 32'(cnt_out[3:2]), 32'd0);

        // Wrap on ch2, saturate on ch3
        cnt_sat = 4'b1000;
        for (int p = 0; p < 5; p++) begin
            btn_in[3:2] = 2'b11;
            repeat (20) tick();
            check($sformatf("wrap_ch2_p%0d", p), 32'(cnt_out[5:4]), 32'(exp_wrap[p]));
            check($sformatf("sat_ch3_p%0d", p), 32'(cnt_out[7:6]), 32'(exp_sat[p]));
            btn_in[3:2] = 2'b00;
            repeat (20) tick();
        end
        cnt_sat = '0;

        // Clear all, then simultaneous press with clear on ch0's pulse
        cnt_clr = 4'hF;
        tick();
        cnt_clr = 4'h0;
        check("clear_all", 32'(cnt_out), 32'd0);
        btn_in = 4'hF;
        repeat (18) tick();
        check("simul_lvl", 32'(btn_lvl), 32'hF);
        tick();
        check("simul_press", 32'(btn_press), 32'hF);
        check("simul_cnt_before", 32'(cnt_out), 32'd0);
        cnt_clr = 4'b0001;
        tick();
        cnt_clr = 4'b0000;
        check("simul_cnt_after", 32'(cnt_out), 32'b01_01_01_00);
        btn_in = 4'h0;
        repeat (20) tick();

        // Reset in the middle of ch2's debounce (timer at 10)
        btn_in[2] = 1'b1;
        repeat (12) tick();
        rstn = 1'b0;
        #1;
        check("rst_outputs_now", {btn_lvl, btn_press, btn_rel, cnt_out, long_press}, 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("rst_outputs_c%0d", j), {btn_lvl, btn_press, btn_rel, cnt_out, long_press}, 32'd0);
        end
        rstn = 1'b1;
        repeat (17) tick();
        check("rst_lvl_t17", 32'(btn_lvl[2]), 32'd0);
        tick();
        check("rst_lvl_t18", 32'(btn_lvl[2]), 32'd1);
        repeat (2) tick();
        check("rst_cnt_t20", 32'(cnt_out), 32'b00_01_00_00);
        btn_in[2] = 1'b0;
        repeat (20) tick();

        // Bring ch0 to 2, then hold it
        press_ch(0);
        press_ch(0);
        check("long_pre_cnt", 32'(cnt_out[1:0]), 32'd2);
        btn_in[0] = 1'b1;
        repeat (20) tick();
        check("long_press_cnt3", 32'(cnt_out[1:0]), 32'd3);
`ifdef BTN_CTRL_LONG_PRESS_EN
        seen_long = '0;
        for (int t = 21; t < 82; t++) begin
            tick();
            seen_long |= long_press;
        end
        check("long_early", 32'(seen_long), 32'd0);
        tick();
        check("long_pulse_t82", 32'(long_press), 32'd1);
        tick();
        check("long_pulse_t83", 32'(long_press[0]), 32'd0);
        check("long_cnt_cleared", 32'(cnt_out[1:0]), 32'd0);
        seen_long = '0;
        for (int t = 84; t <= 200; t++) begin
            tick();
            seen_long |= long_press;
        end
        check("long_single_pulse", 32'(seen_long), 32'd0);
        check("long_cnt_still0", 32'(cnt_out[1:0]), 32'd0);
`else
        seen_long = '0;
        for (int t = 21; t <= 200; t++) begin
            tick();
            seen_long |= long_press;
        end
        check("long_disabled", 32'(seen_long), 32'd0);
        check("long_disabled_cnt", 32'(cnt_out[1:0]), 32'd3);
`endif
        btn_in[0] = 1'b0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_ctrl_select.md
Name: btn_ctrl_select

Overview:
- Parametrised front-panel input block: N push-buttons in; debounced levels, press/release pulses and per-channel selector counters out.
- Replaces the open-coded single shared debouncer and hard-wired FraimSel/SelHDMI/SelStat counters in the top level.
- Every channel has its own debounce timer, so activity on one button never delays another.
- Counter outputs drive Drone_Cam_BD select inputs and board LEDs.

Parameters:
NUM_BTN, 4, number of button channels
SYNC_STAGES, 2, synchroniser depth per channel (min 2)
DEB_CNT, 1048575, cycles an input must hold a new level before it is accepted (min 2)
DEB_W, 20, debounce timer width; must satisfy 2^DEB_W > DEB_CNT
CNT_W, 2, selector counter width per channel
CNT_MAX, 3, last counter value (<= 2^CNT_W-1)
LONG_CNT, 50000000, long-press threshold in cycles (feature only)

Ports:
clk  in  1  system clock (FCLK-derived)
rstn  in  1  asynchronous active-low reset
btn_in  in  NUM_BTN  raw asynchronous button inputs
cnt_sat  in  NUM_BTN  per channel: 1 = saturate at CNT_MAX, 0 = wrap to 0
cnt_clr  in  NUM_BTN  per channel synchronous clear of the counter
btn_lvl  out  NUM_BTN  debounced level
btn_press  out  NUM_BTN  1-cycle pulse on debounced rising edge
btn_rel  out  NUM_BTN  1-cycle pulse on debounced falling edge
cnt_out  out  NUM_BTN*CNT_W  selector counters; channel i at [i*CNT_W +: CNT_W]
long_press  out  NUM_BTN  long-press pulse (tied 0 without feature)

Behaviour:
- Reset: one clock, asynchronous active-low `rstn`. Asserting `rstn` clears every register, including synchronisers, debounce timers and counters. All outputs are 0 while `rstn` is low.
- Reset mid-operation: a debounce in progress is discarded. After reset release, a held button is seen as a fresh press: after SYNC_STAGES+DEB_CNT cycles it produces a press pulse.
- Synchroniser: SYNC_STAGES flops per bit; `s` is the last stage.
- Debounce (per channel), with `stb` = debounced state and `tmr` = timer:
  - If `s` == `stb`: `tmr` <= 0.
  - Otherwise `tmr` increments.
  - When `s` != `stb` and `tmr` == DEB_CNT-1: `stb` <= `s` and `tmr` <= 0.
- A glitch shorter than DEB_CNT cycles produces no output activity, and its timer restarts from 0.
- Latency: raw edge to `btn_lvl` change is SYNC_STAGES+DEB_CNT cycles.
- `btn_press` = `stb` & ~`stb_d`; `btn_rel` = ~`stb` & `stb_d`. Both are registered, one cycle after the `btn_lvl` change.
- Counter (per channel), with priority clear > press:
  - `cnt_clr` high: `cnt` <= 0.
  - Press pulse and `cnt` < CNT_MAX: `cnt` + 1.
  - Press pulse and `cnt` == CNT_MAX: 0 if `cnt_sat`=0, hold CNT_MAX if `cnt_sat`=1.
  - Clear and press in the same cycle: result is 0 and the press is lost.
- Counter update appears the cycle after the `btn_press` pulse.
- Channels are fully independent; simultaneous presses on any subset all count.
- `cnt_sat` and `cnt_clr` are sampled every cycle and need no synchronisation (same clock domain).

Optional Feature:
- Macro: BTN_CTRL_LONG_PRESS_EN.
- Defined:
  - Per-channel hold timer (width $clog2(LONG_CNT+1)) counts while `stb`=1 and clears when `stb`=0.
  - When it reaches LONG_CNT-1, `long_press` pulses for 1 cycle and that channel's counter is cleared to 0 (long press = "reset selection").
  - The timer then holds at LONG_CNT-1 until release, so only one pulse is issued per hold.
  - A `cnt_clr` in the same cycle has the same effect.
- Undefined: no hold timer; `long_press` is constant 0.

Decomposition:
- Package `drone_cam_ui_pkg`: default constants (DEB_CNT_DEFAULT, LONG_CNT_DEFAULT, SYNC_STAGES_DEFAULT) and channel index constants CH_FRAME=0, CH_HDMI=2, CH_STAT=3 used by the top level.
- Sub-module `btn_debounce_ch`: single-channel synchroniser + debounce + edge detect (+ optional hold timer). Instantiated NUM_BTN times in a generate loop.
- Counter logic stays in the parent.

Test Plan (all with DEB_CNT=16, SYNC_STAGES=2, CNT_W=2, CNT_MAX=3, LONG_CNT=64):
- Clean press:
  - Stimulus: btn_in[0] 0→1 held 40 cycles.
  - Required: btn_lvl[0] rises exactly 18 cycles after the edge; btn_press[0] is a single 1-cycle pulse the next cycle; cnt_out[1:0]=1 one cycle after that; btn_rel fires after release+18+1.
- Bounce rejection:
  - Stimulus: btn_in[1] toggles every 5 cycles for 100 cycles, then settles at 0.
  - Required: btn_lvl[1], btn_press[1], btn_rel[1] stay 0; cnt_out[3:2]=0.
- Wrap vs saturate:
  - Stimulus: 5 clean presses on ch2 with cnt_sat[2]=0, and on ch3 with cnt_sat[3]=1.
  - Required: ch2 sequence 1,2,3,0,1; ch3 sequence 1,2,3,3,3.
- Simultaneous events:
  - Stimulus: ch0..ch3 pressed on the same cycle; cnt_clr[0] asserted exactly on ch0's press pulse.
  - Required: ch1..ch3 each increment by 1 on the same cycle; ch0 reads 0.
- Reset mid-debounce:
  - Stimulus: rstn low for 3 cycles while btn_in[2]=1 and its timer is at 10.
  - Required: all outputs 0 during reset; after release btn_lvl[2] rises 18 cycles later and counter = 1.
- Long press (BTN_CTRL_LONG_PRESS_EN):
  - Stimulus: set ch0 counter to 2, then hold btn_in[0] for 200 cycles.
  - Required: press gives 3; then exactly one long_press[0] pulse 64 cycles after the btn_lvl rise; cnt reads 0.
